// File: rtl/pixie_dma_master.sv
// pixie_dma_master: the CPU-side half of a Pixie-style display DMA.
// Machine-cycle sequencer (fetch/execute/DMA/interrupt state codes) driven by
// a bus tick, plus the R0 DMA pointer, one memory read per DMA cycle, and
// interrupt acknowledge with an interrupt-enable flag.
module pixie_dma_master #(
   parameter int          CYCLE_TICKS = 8,
   parameter logic [15:0] R0_RESET    = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        DMAO,
   input  logic        INT,
   input  logic        ie_set,
   input  logic        r0_load,
   input  logic [15:0] r0_value,
   input  logic [7:0]  mem_data,
   output logic [1:0]  SC,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic [7:0]  data_out,
   output logic        int_ack,
   output logic [15:0] r0
);

   localparam int            TW          = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
   localparam logic [TW-1:0] TC_LAST     = TW'(CYCLE_TICKS - 1);
   // The read strobe is launched on the tick that moves tc from 1 to 2, so it
   // is high during the first clk of tick 2.
   localparam logic [TW-1:0] TC_PRE_READ = TW'(1);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_DMA   = 2'd2,
      S_INT   = 2'd3
   } sc_e;

   logic [TW-1:0] tc_q, tc_d;
   sc_e           sc_q, sc_d;
   logic [15:0]   r0_q, r0_d;
   logic          ie_q, ie_d;
   logic          mem_rd_q, mem_rd_d;
   logic          rd_dly_q, rd_dly_d;
   logic [7:0]    data_q, data_d;
   logic          ack_q, ack_d;
   logic          wrap;

   assign wrap = (tc_q == TC_LAST);

   // Next-state logic: tick counter, state code decision at wrap, R0 pointer,
   // interrupt enable, read strobe and data capture.
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned,
      // which would otherwise infer a latch.
      tc_d     = tc_q;
      sc_d     = sc_q;
      r0_d     = r0_q;
      ie_d     = ie_q;
      mem_rd_d = 1'b0;
      ack_d    = 1'b0;
      // Memory data is valid the clk after the strobe; capture exactly once,
      // independent of clk_enable, so a slow bus tick cannot repeat it.
      rd_dly_d = mem_rd_q;
      data_d   = rd_dly_q ? mem_data : data_q;

      if (clk_enable) begin
         tc_d = wrap ? '0 : tc_q + 1'b1;

         if (ie_set) ie_d = 1'b1;

         if (sc_q == S_DMA && tc_q == TC_PRE_READ) mem_rd_d = 1'b1;

         if (sc_q == S_DMA && wrap) r0_d = r0_q + 16'd1;
         // An explicit load beats the end-of-DMA increment.
         if (r0_load) r0_d = r0_value;

         if (wrap) begin
            if (DMAO) begin
               sc_d = S_DMA;
            end else if (INT && ie_q) begin
               // Entering S3 clears IE even if ie_set arrives on the same tick.
               sc_d  = S_INT;
               ie_d  = 1'b0;
               ack_d = 1'b1;
            end else if (sc_q == S_FETCH) begin
               sc_d = S_EXEC;
            end else begin
               sc_d = S_FETCH;
            end
         end
      end
   end

   // State register with asynchronous reset; all outputs come straight from here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tc_q     <= '0;
         sc_q     <= S_EXEC;
         r0_q     <= R0_RESET;
         ie_q     <= 1'b1;
         mem_rd_q <= 1'b0;
         rd_dly_q <= 1'b0;
         data_q   <= 8'h00;
         ack_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values from
         // before this edge, independent of statement order.
         tc_q     <= tc_d;
         sc_q     <= sc_d;
         r0_q     <= r0_d;
         ie_q     <= ie_d;
         mem_rd_q <= mem_rd_d;
         rd_dly_q <= rd_dly_d;
         data_q   <= data_d;
         ack_q    <= ack_d;
      end
   end

   assign SC       = sc_q;
   assign mem_addr = r0_q;
   assign r0       = r0_q;
   assign mem_rd   = mem_rd_q;
   assign data_out = data_q;
   assign int_ack  = ack_q;

endmodule
